// File: rtl/alu_ctrl.sv
// Accumulator sequencer for an external combinational ALU: it accepts one instruction, runs it
// through EXEC and WB, then retires it into acc with a one-cycle done pulse.
module alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  output logic [WIDTH-1:0] acc,
  output logic             zero,
  output logic             done,
  output logic             busy,
  output logic [7:0]       icount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t           state;
  logic             ready_r;
  logic [2:0]       op_p0;
  logic [WIDTH-1:0] operand_p0;
  logic [WIDTH-1:0] result_p1;

  // ready_r shadows (state == IDLE) so that in_ready and busy come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ready_r    <= 1'b1;
      acc        <= '0;
      zero       <= 1'b1;
      done       <= 1'b0;
      icount     <= 8'd0;
      op_p0      <= 3'd0;
      operand_p0 <= '0;
      result_p1  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        // p0: capture the instruction on accept
        IDLE: begin
          if (in_valid) begin
            op_p0      <= in_op;
            operand_p0 <= in_data;
            ready_r    <= 1'b0;
            state      <= EXEC;
          end
        end
        // p1: latch the ALU result
        EXEC: begin
          result_p1 <= alu_y;
          state     <= WB;
        end
        // p2: retire into the accumulator
        WB: begin
          acc     <= result_p1;
          zero    <= (result_p1 == '0);
          done    <= 1'b1;
          icount  <= icount + 8'd1;
          ready_r <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          ready_r <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign in_ready = ready_r;
  assign busy     = ~ready_r;
  assign alu_op   = op_p0;
  assign alu_b    = operand_p0;
  assign alu_a    = acc;

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: directed scenarios with literal expectations plus random
// traffic compared every cycle against a transaction-level model.
module tb_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready;
  logic [2:0] in_op, alu_op;
  logic [7:0] in_data, alu_a, alu_b, alu_y, acc, icount;
  logic       zero, done, busy;

  int n_checks = 0;
  int n_errors = 0;

  alu_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_data(in_data), .alu_op(alu_op), .alu_a(alu_a),
    .alu_b(alu_b), .alu_y(alu_y), .acc(acc), .zero(zero), .done(done),
    .busy(busy), .icount(icount)
  );

  // Bench ALU: modulo-256 add, whatever the opcode.
  assign alu_y = alu_a + alu_b;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted instruction retires two edges after its accept edge,
  // adding its operand to the accumulator.
  bit         m_known = 0;
  int         m_left  = 0;
  logic [7:0] m_acc, m_pend, m_b, m_icount;
  logic [2:0] m_op;
  logic       m_done;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_known  = 1;
      m_left   = 0;
      m_acc    = 8'd0;
      m_icount = 8'd0;
      m_op     = 3'd0;
      m_b      = 8'd0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_acc    = m_pend;
        m_icount = m_icount + 8'd1;
        m_done   = 1'b1;
      end
    end else if (in_valid) begin
      m_op   = in_op;
      m_b    = in_data;
      m_pend = m_acc + in_data;
      m_left = 2;
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("in_ready", in_ready, m_left == 0);
      chk("busy",     busy,     m_left != 0);
      chk("acc",      acc,      m_acc);
      chk("alu_a",    alu_a,    m_acc);
      chk("zero",     zero,     m_acc == 8'd0);
      chk("done",     done,     m_done);
      chk("icount",   icount,   m_icount);
      chk("alu_op",   alu_op,   m_op);
      chk("alu_b",    alu_b,    m_b);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] seen;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_data = 8'd0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_acc", acc, 8'h00);
    chk("rst_zero", zero, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_icount", icount, 8'd0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);

    // Single instruction
    in_valid = 1'b1; in_op = 3'h2; in_data = 8'h05;
    tick();
    in_valid = 1'b0;
    chk("single_exec_op", alu_op, 3'h2);
    chk("single_exec_b", alu_b, 8'h05);
    chk("single_exec_busy", busy, 1'b1);
    tick();
    chk("single_wb_done", done, 1'b0);
    tick();
    chk("single_acc", acc, 8'h05);
    chk("single_zero", zero, 1'b0);
    chk("single_done", done, 1'b1);
    chk("single_icount", icount, 8'd1);
    tick();
    chk("single_done_drop", done, 1'b0);

    // Back-to-back from a cleared accumulator
    rst = 1'b1; tick(); rst = 1'b0;
    in_valid = 1'b1; in_op = 3'h0; in_data = 8'h80;
    tick(); tick(); tick();
    chk("b2b_acc1", acc, 8'h80);
    chk("b2b_done1", done, 1'b1);
    chk("b2b_ready1", in_ready, 1'b1);
    tick();
    chk("b2b_accept2", busy, 1'b1);
    chk("b2b_done_gap", done, 1'b0);
    tick(); tick();
    in_valid = 1'b0;
    chk("b2b_acc2", acc, 8'h00);
    chk("b2b_zero2", zero, 1'b1);
    chk("b2b_done2", done, 1'b1);
    chk("b2b_icount", icount, 8'd2);
    tick();

    // Offers while busy are ignored
    in_valid = 1'b1; in_op = 3'h1; in_data = 8'h01;
    tick();
    in_op = 3'h7; in_data = 8'hFF;
    tick(); tick();
    in_valid = 1'b0;
    chk("busy_acc", acc, 8'h01);
    chk("busy_icount", icount, 8'd3);
    chk("busy_alu_b", alu_b, 8'h01);
    chk("busy_alu_op", alu_op, 3'h1);
    tick();
    chk("busy_icount2", icount, 8'd3);
    chk("busy_ready", in_ready, 1'b1);

    // Reset while in WB abandons the instruction
    rst = 1'b1; tick(); rst = 1'b0;
    in_valid = 1'b1; in_op = 3'h3; in_data = 8'h10;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_acc", acc, 8'h00);
    chk("midrst_done", done, 1'b0);
    chk("midrst_icount", icount, 8'd0);
    chk("midrst_ready", in_ready, 1'b1);
    tick();
    chk("midrst_done_late", done, 1'b0);
    chk("midrst_icount_late", icount, 8'd0);

    // icount wrap over 256 instructions, cycling every opcode
    seen = 8'h00;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; in_op = 3'(i); in_data = 8'h00;
      tick();
      in_valid = 1'b0;
      seen[alu_op] = 1'b1;
      tick(); tick();
    end
    chk("wrap_icount", icount, 8'd0);
    chk("wrap_opcodes", seen, 8'hFF);
    chk("wrap_zero", zero, 1'b1);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 39) == 0);
      in_valid = $urandom_range(0, 2) != 0;
      in_op    = 3'($urandom);
      in_data  = 8'($urandom);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
